// File: rtl/pc_if.sv
// rtl/pc_if.sv - next-PC operand/result bundle between decode/ALU and the PC unit
interface pc_if #(
  parameter int XLEN = 32
);
  logic            pc_en;
  logic [1:0]      pc_source;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] immediate;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_q;
`ifdef PC_MISALIGN_CHECK_EN
  logic            misaligned;
  logic            misaligned_q;
`endif

  modport master (
    output pc_en, pc_source, rs1_data, immediate, alu_result, pc_in,
`ifdef PC_MISALIGN_CHECK_EN
    input  misaligned, misaligned_q,
`endif
    input  pc_out, pc_q
  );

  modport slave (
    input  pc_en, pc_source, rs1_data, immediate, alu_result, pc_in,
`ifdef PC_MISALIGN_CHECK_EN
    output misaligned, misaligned_q,
`endif
    output pc_out, pc_q
  );
endinterface

// File: rtl/program_counter_unit.sv
// rtl/program_counter_unit.sv - next-PC mux and fetch PC register (optional PC_MISALIGN_CHECK_EN)
module program_counter_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input logic clk,
  input logic rst_n,
  pc_if.slave bus
);
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_plus_imm;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_next_pc;
  logic            w_branch_taken;
  logic            w_load;
  logic [XLEN-1:0] r_pc;

  assign w_pc_plus4     = bus.pc_in + XLEN'(4);
  assign w_pc_plus_imm  = bus.pc_in + bus.immediate;
  assign w_jalr_sum     = bus.rs1_data + bus.immediate;
  // Only an exact 1 counts as taken; any other ALU value falls through.
  assign w_branch_taken = (bus.alu_result == XLEN'(1));

  always_comb begin
    w_next_pc = w_pc_plus4;
    case (bus.pc_source)
      2'b00:   w_next_pc = {w_jalr_sum[XLEN-1:1], 1'b0};
      2'b01:   w_next_pc = w_pc_plus_imm;
      2'b10:   w_next_pc = w_branch_taken ? w_pc_plus_imm : w_pc_plus4;
      default: w_next_pc = w_pc_plus4;
    endcase
  end

`ifdef PC_MISALIGN_CHECK_EN
  logic w_misaligned;
  logic r_misaligned_q;

  assign w_misaligned = |w_next_pc[1:0];
  // A misaligned target is flagged but never becomes the fetch address.
  assign w_load       = bus.pc_en & ~w_misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misaligned_q <= 1'b0;
    end else if (bus.pc_en) begin
      r_misaligned_q <= w_misaligned;
    end
  end

  assign bus.misaligned   = w_misaligned;
  assign bus.misaligned_q = r_misaligned_q;
`else
  assign w_load = bus.pc_en;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_VECTOR;
    end else if (w_load) begin
      r_pc <= w_next_pc;
    end
  end

  assign bus.pc_out = w_next_pc;
  assign bus.pc_q   = r_pc;
endmodule

// File: tb/tb_program_counter_unit.sv
// tb/tb_program_counter_unit.sv - scoreboard bench for program_counter_unit
module tb_program_counter_unit;
  localparam int K_PC_OUT = 0;
  localparam int K_PC_Q   = 1;
  localparam int K_MIS    = 2;
  localparam int K_MIS_Q  = 3;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic rst_n;
  logic chk_req;
  int   total;
  int   bad;
  exp_t sb[$];

  pc_if #(.XLEN(32)) bus ();

  program_counter_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    if (chk_req && sb.size() > 0) begin
      e   = sb.pop_front();
      act = 32'hDEAD_BEEF;
      case (e.kind)
        K_PC_OUT: act = bus.pc_out;
        K_PC_Q:   act = bus.pc_q;
`ifdef PC_MISALIGN_CHECK_EN
        K_MIS:    act = {31'b0, bus.misaligned};
        K_MIS_Q:  act = {31'b0, bus.misaligned_q};
`endif
        default:  act = 32'hDEAD_BEEF;
      endcase
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic drive(input logic [1:0] src, input logic [31:0] pin, input logic [31:0] rs1,
                       input logic [31:0] imm, input logic [31:0] alu, input logic en);
    @(posedge clk);
    #1;
    bus.pc_source  = src;
    bus.pc_in      = pin;
    bus.rs1_data   = rs1;
    bus.immediate  = imm;
    bus.alu_result = alu;
    bus.pc_en      = en;
  endtask

  task automatic chk(input int kind, input string name, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
    chk_req = 1'b1;
    @(negedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total   = 0;
    bad     = 0;
    chk_req = 1'b0;
    rst_n   = 1'b0;
    bus.pc_source  = 2'b11;
    bus.pc_in      = 32'h1000;
    bus.rs1_data   = 32'h2000;
    bus.immediate  = 32'h10;
    bus.alu_result = 32'h0;
    bus.pc_en      = 1'b1;

    // Reset holds pc_q even with pc_en high across edges.
    chk(K_PC_Q, "reset_pc_q", 32'h0);
    @(posedge clk);
    chk(K_PC_Q, "reset_overrides_en", 32'h0);
    drive(2'b11, 32'h1000, 32'h2000, 32'h10, 32'h0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    chk(K_PC_Q, "hold_after_release", 32'h0);

    drive(2'b00, 32'h1000, 32'h2000, 32'h10, 32'h0, 1'b0);
    chk(K_PC_OUT, "jalr", 32'h2010);
    drive(2'b00, 32'h1000, 32'h2001, 32'h0, 32'h0, 1'b0);
    chk(K_PC_OUT, "jalr_clear_bit0", 32'h2000);
    drive(2'b01, 32'h1000, 32'h2000, 32'h10, 32'h0, 1'b0);
    chk(K_PC_OUT, "jal", 32'h1010);
    drive(2'b01, 32'h1000, 32'h2000, 32'hFFFF_FFF0, 32'h0, 1'b0);
    chk(K_PC_OUT, "jal_neg_imm", 32'h0FF0);
    drive(2'b10, 32'h1000, 32'h2000, 32'h10, 32'h1, 1'b0);
    chk(K_PC_OUT, "br_taken", 32'h1010);
    drive(2'b10, 32'h1000, 32'h2000, 32'h10, 32'h0, 1'b0);
    chk(K_PC_OUT, "br_not_taken", 32'h1004);
    drive(2'b10, 32'h1000, 32'h2000, 32'h10, 32'h2, 1'b0);
    chk(K_PC_OUT, "br_alu2", 32'h1004);
    drive(2'b10, 32'h1000, 32'h2000, 32'h10, 32'hFFFF_FFFF, 1'b0);
    chk(K_PC_OUT, "br_alu_all_ones", 32'h1004);
    drive(2'b11, 32'h1000, 32'h2000, 32'h10, 32'h1, 1'b0);
    chk(K_PC_OUT, "seq", 32'h1004);
    drive(2'b11, 32'hFFFF_FFFC, 32'h2000, 32'h10, 32'h0, 1'b0);
    chk(K_PC_OUT, "seq_wrap", 32'h0000_0000);
    chk(K_PC_Q, "stall_no_load", 32'h0);

    drive(2'b11, 32'h1000, 32'h2000, 32'h10, 32'h0, 1'b1);
    drive(2'b11, 32'h3000, 32'h2000, 32'h10, 32'h0, 1'b0);
    chk(K_PC_Q, "load_seq", 32'h1004);
    drive(2'b01, 32'h5000, 32'h2000, 32'h10, 32'h0, 1'b0);
    chk(K_PC_Q, "stall_hold", 32'h1004);
    drive(2'b01, 32'h3000, 32'h2000, 32'h10, 32'h0, 1'b1);
    drive(2'b01, 32'h3000, 32'h2000, 32'h10, 32'h0, 1'b0);
    chk(K_PC_Q, "load_jal", 32'h3010);

    @(posedge clk);
    #1;
    bus.pc_en = 1'b1;
    rst_n = 1'b0;
    chk(K_PC_Q, "async_reset", 32'h0);
    drive(2'b11, 32'h1000, 32'h2000, 32'h10, 32'h0, 1'b0);
    rst_n = 1'b1;

`ifdef PC_MISALIGN_CHECK_EN
    drive(2'b11, 32'h1000, 32'h2000, 32'h10, 32'h0, 1'b1);
    drive(2'b01, 32'h1000, 32'h2000, 32'h2, 32'h0, 1'b0);
    chk(K_MIS, "misaligned_comb", 32'h1);
    drive(2'b01, 32'h1000, 32'h2000, 32'h2, 32'h0, 1'b1);
    drive(2'b01, 32'h1000, 32'h2000, 32'h2, 32'h0, 1'b0);
    chk(K_PC_Q, "misaligned_hold", 32'h1004);
    chk(K_MIS_Q, "misaligned_q_set", 32'h1);
    drive(2'b01, 32'h1000, 32'h2000, 32'h20, 32'h0, 1'b1);
    drive(2'b11, 32'h1000, 32'h2000, 32'h10, 32'h0, 1'b0);
    chk(K_PC_Q, "aligned_load", 32'h1020);
    chk(K_MIS_Q, "misaligned_q_clear", 32'h0);
`endif

    @(negedge clk);
    if (sb.size() > 0) begin
      total += sb.size();
      bad   += sb.size();
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
